// File: rtl/adder_sched_pkg.sv
// Shared definitions for the round-robin adder scheduler: default sizes,
// the response FSM state type and the completed-response counter width.
package adder_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int COUNT_W = 16;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Combinational arbiter: first valid requester found searching upward from
// ptr (round-robin) or from index 0 (fixed priority), gated by enable.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            fixed_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW-1:0] base_s;
  logic [IDW:0]   cand_s;
  logic           found_s;
  logic           hit_s;

  // Walk the candidates in priority order, latching the first valid one.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = '0;
    base_s  = fixed_i ? '0 : ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, base_s} + (IDW+1)'(k);
      cand_s = (cand_s >= (IDW+1)'(NREQ)) ? cand_s - (IDW+1)'(NREQ) : cand_s;
      hit_s  = !found_s && en_i && req_i[cand_s[IDW-1:0]];
      grant_o[cand_s[IDW-1:0]] = grant_o[cand_s[IDW-1:0]] | hit_s;
      idx_o   = hit_s ? cand_s[IDW-1:0] : idx_o;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Shares one WIDTH-bit adder between NREQ requesters: arbitrates, adds the
// winner's operands and holds {carry, sum, id} until the consumer takes it.
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_fixed_prio,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  input  logic                  rsp_ready,
  output logic [COUNT_W-1:0]    op_count
);

  state_e             state_q;
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic               rsp_carry_q;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               can_accept_s;
  logic               rsp_hs_s;
  logic               xfer_s;
  logic [NREQ-1:0]    grant_s;
  logic [IDW-1:0]     gidx_s;
  logic [WIDTH-1:0]   opa_s, opb_s;
  logic [WIDTH:0]     sum_s;

  assign can_accept_s = !rsp_valid_q || rsp_ready;
  assign rsp_hs_s     = rsp_valid_q && rsp_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .fixed_i (cfg_fixed_prio),
    .en_i    (can_accept_s && !rst),
    .grant_o (grant_s),
    .idx_o   (gidx_s)
  );

  assign xfer_s    = |(grant_s & req_valid);
  assign req_ready = grant_s;

  assign opa_s = req_a[gidx_s*WIDTH +: WIDTH];
  assign opb_s = req_b[gidx_s*WIDTH +: WIDTH];
  assign sum_s = {1'b0, opa_s} + {1'b0, opb_s};

  // Pointer advances past the winner; counter tracks response handshakes.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (xfer_s) begin
      ptr_d = (gidx_s == IDW'(NREQ - 1)) ? '0 : gidx_s + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
    if (rsp_hs_s) begin
      count_d = count_q + COUNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Response FSM with the result register; a new transfer may overlap a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (xfer_s) begin
        rsp_id_q    <= gidx_s;
        rsp_sum_q   <= sum_s[WIDTH-1:0];
        rsp_carry_q <= sum_s[WIDTH];
      end
      case (state_q)
        EMPTY: begin
          if (xfer_s) begin
            state_q     <= FULL;
            rsp_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (!xfer_s && rsp_ready) begin
            state_q     <= EMPTY;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Self-checking bench for adder_rr_sched: directed scenarios plus random
// traffic, all compared every cycle against a transaction-level model.
module tb_adder_rr_sched;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_fixed_prio;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic           rsp_ready;
  logic [15:0]    op_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_valid;
  int m_id, m_sum, m_carry, m_ptr, m_count;

  adder_rr_sched #(.NREQ(N), .WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_fixed_prio (cfg_fixed_prio),
    .req_valid      (req_valid),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_sum        (rsp_sum),
    .rsp_carry      (rsp_carry),
    .rsp_ready      (rsp_ready),
    .op_count       (op_count)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    int start;
    if (rst || (m_valid && !rsp_ready)) return -1;
    start = cfg_fixed_prio ? 0 : m_ptr;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: check outputs mid-cycle against the model, then advance it.
  task automatic step();
    int g;
    int total;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    n_checks++;
    if (req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
    end
    n_checks++;
    if (rsp_valid !== m_valid) begin
      n_fail++;
      $display("FAIL rsp_valid: got %b expected %b at %0t", rsp_valid, m_valid, $time);
    end
    n_checks++;
    if (rsp_id !== 2'(m_id) || rsp_sum !== 8'(m_sum) || rsp_carry !== 1'(m_carry)) begin
      n_fail++;
      $display("FAIL rsp_data: got id=%0d sum=%h c=%b expected id=%0d sum=%h c=%0d at %0t",
               rsp_id, rsp_sum, rsp_carry, m_id, m_sum, m_carry, $time);
    end
    n_checks++;
    if (op_count !== 16'(m_count)) begin
      n_fail++;
      $display("FAIL op_count: got %0d expected %0d at %0t", op_count, m_count, $time);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_sum = 0; m_carry = 0; m_ptr = 0; m_count = 0;
    end else begin
      if (m_valid && rsp_ready) m_count = (m_count + 1) % 65536;
      if (g >= 0) begin
        total   = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
        m_sum   = total % 256;
        m_carry = total / 256;
        m_id    = g;
        m_valid = 1;
        m_ptr   = (g + 1) % N;
      end else if (m_valid && rsp_ready) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = 8'(a);
    req_b[i*W +: W] = 8'(b);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_ops(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_fixed_prio = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0;
    step(); step();
    req_valid = 4'b1111;
    step();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_ops(2, 8'h7F, 8'h01);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step(); step();
  endtask

  task automatic test_carry();
    set_ops(0, 8'hFF, 8'h02);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step(); step();
  endtask

  task automatic test_round_robin();
    rst = 1'b1; step(); rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    step(); step();
  endtask

  task automatic test_fixed();
    cfg_fixed_prio = 1'b1;
    req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin rand_ops(); step(); end
    req_valid = 4'b1000;
    step(); step();
    req_valid = '0;
    cfg_fixed_prio = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0110;
    rand_ops();
    step();
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    rsp_ready = 1'b1;
    step(); step();
    req_valid = '0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000;
    rand_ops();
    step();
    rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1110;
    rsp_ready = 1'b1;
    step(); step(); step();
    req_valid = '0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid      = N'($urandom_range(0, 15));
      rsp_ready      = ($urandom_range(0, 3) != 0);
      cfg_fixed_prio = ($urandom_range(0, 7) == 0);
      rst            = ($urandom_range(0, 63) == 0);
      rand_ops();
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_fixed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
